spi_ctl_tx: RTL and testbench



---
 rtl/spi_ctl_tx.sv | 161 ++++++++++++++++
 tb/tb_spi_ctl_tx.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ctl_tx.sv
// SPI mode-0 controller transmitter: shifts bytes MSB-first, and bytes offered back-to-back share one CSN burst.
// Defining SPI_CTL_TX_RX_EN adds the receive path (spi_sdi, rx_data, rx_stb).
//
// state | meaning
// IDLE  | waiting for a byte, CSN high
// LEAD  | CSN setup before the first SCK rise
// HIGH  | SCK high; peripheral samples on entry
// LOW   | SCK low; next bit already on SDO
// TAIL  | CSN hold after the last SCK fall
// GAP   | minimum CSN-high time before IDLE
module spi_ctl_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       stb,
    output logic       ready,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_csn,
    output logic       spi_sdo
`ifdef SPI_CTL_TX_RX_EN
    ,
    input  logic       spi_sdi,
    output logic [7:0] rx_data,
    output logic       rx_stb
`endif
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TAIL,
        GAP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_idx;
    logic [6:0]       tx_shift;
    logic             phase_end;
    logic             last_bit;

    // Phase timer is a down-counter reloaded on every state change.
    assign phase_end = (div_cnt == '0);
    assign last_bit  = (bit_idx == 3'd0);
    assign ready     = (state == IDLE) || (state == HIGH && phase_end && last_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= DIV_LOAD;
            bit_idx  <= 3'd0;
            tx_shift <= '0;
            spi_sck  <= 1'b0;
            spi_csn  <= 1'b1;
            spi_sdo  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && !phase_end) begin
                div_cnt <= div_cnt - DIV_ONE;
            end
            case (state)
                IDLE: begin
                    if (stb) begin
                        tx_shift <= data[6:0];
                        spi_sdo  <= data[7];
                        spi_csn  <= 1'b0;
                        bit_idx  <= 3'd7;
                        div_cnt  <= DIV_LOAD;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (phase_end) begin
                        spi_sck <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        spi_sck <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        if (!last_bit) begin
                            spi_sdo  <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                            bit_idx  <= bit_idx - 3'd1;
                            state    <= LOW;
                        end else begin
                            done <= 1'b1;
                            // A waiting byte continues the burst with no SCK gap.
                            if (stb) begin
                                tx_shift <= data[6:0];
                                spi_sdo  <= data[7];
                                bit_idx  <= 3'd7;
                                state    <= LOW;
                            end else begin
                                state <= TAIL;
                            end
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        spi_sck <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= HIGH;
                    end
                end
                TAIL: begin
                    if (phase_end) begin
                        spi_csn <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        div_cnt <= DIV_LOAD;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_CTL_TX_RX_EN
    logic [6:0] rx_shift;

    // SDI is taken in the last HIGH cycle, i.e. just before SCK falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_stb   <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            if (state == HIGH && phase_end) begin
                rx_shift <= {rx_shift[5:0], spi_sdi};
                if (last_bit) begin
                    rx_data <= {rx_shift, spi_sdi};
                    rx_stb  <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_ctl_tx.sv
// Bench for spi_ctl_tx: scoreboard of expected SDO bits, SCK rise cycles and done cycles.
// In the SPI_CTL_TX_RX_EN build SDI is looped back to SDO and received bytes are scored too.
module tb_spi_ctl_tx;

    localparam int DIV = 4;

    typedef struct packed {
        logic b;
        int   cyc;
    } rise_t;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       stb;
    logic       ready;
    logic       done;
    logic       spi_sck;
    logic       spi_csn;
    logic       spi_sdo;

    logic [7:0] data1;
    logic       stb1;
    logic       ready1;
    logic       done1;
    logic       sck1;
    logic       csn1;
    logic       sdo1;

`ifdef SPI_CTL_TX_RX_EN
    logic       spi_sdi;
    logic [7:0] rx_data;
    logic       rx_stb;
    logic [7:0] rx_data1;
    logic       rx_stb1;
    assign spi_sdi = spi_sdo;
`endif

    spi_ctl_tx #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .data(data), .stb(stb), .ready(ready), .done(done),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdo(spi_sdo)
`ifdef SPI_CTL_TX_RX_EN
        , .spi_sdi(spi_sdi), .rx_data(rx_data), .rx_stb(rx_stb)
`endif
    );

    spi_ctl_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .data(data1), .stb(stb1), .ready(ready1), .done(done1),
        .spi_sck(sck1), .spi_csn(csn1), .spi_sdo(sdo1)
`ifdef SPI_CTL_TX_RX_EN
        , .spi_sdi(sdo1), .rx_data(rx_data1), .rx_stb(rx_stb1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    rise_t      exp_rise[$];
    int         exp_done[$];
    logic [7:0] exp_rx[$];

    int   rise_cnt = 0;
    int   done_cnt = 0;
    int   hs_cnt   = 0;
    int   hs_cyc   = 0;
    int   rx_cnt   = 0;
    logic prev_sck = 1'b0;

    int   smp_cyc;
    logic smp_sck, smp_csn, smp_sdo, smp_ready, smp_done;
    logic smp1_sck, smp1_sdo, smp1_done, smp1_hs;

    // Samples everything at the falling edge, then returns just after the next rising edge.
    task automatic step();
        rise_t e;
        int    dc;
        @(negedge clk);
        smp_cyc   = cyc;
        smp_sck   = spi_sck;
        smp_csn   = spi_csn;
        smp_sdo   = spi_sdo;
        smp_ready = ready;
        smp_done  = done;
        smp1_sck  = sck1;
        smp1_sdo  = sdo1;
        smp1_done = done1;
        smp1_hs   = stb1 && ready1 && !rst;
        if (!rst) begin
            if (spi_sck && !prev_sck) begin
                rise_cnt++;
                n_run++;
                if (exp_rise.size() == 0) begin
                    n_fail++;
                    $display("FAIL sck_rise: unexpected rise at cycle %0d, none expected", cyc);
                end else begin
                    e = exp_rise.pop_front();
                    if (spi_sdo !== e.b || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL sdo_at_rise: got sdo=%b at cycle %0d, expected sdo=%b at cycle %0d",
                                 spi_sdo, cyc, e.b, e.cyc);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                n_run++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_pulse: unexpected done at cycle %0d, none expected", cyc);
                end else begin
                    dc = exp_done.pop_front();
                    if (cyc != dc) begin
                        n_fail++;
                        $display("FAIL done_cycle: got done at cycle %0d, expected cycle %0d", cyc, dc);
                    end
                end
            end
`ifdef SPI_CTL_TX_RX_EN
            if (done || rx_stb) begin
                n_run++;
                if (rx_stb !== done) begin
                    n_fail++;
                    $display("FAIL rx_stb_align: rx_stb=%b done=%b at cycle %0d, expected equal", rx_stb, done, cyc);
                end
            end
            if (rx_stb) begin
                rx_cnt++;
                n_run++;
                if (exp_rx.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_data: unexpected rx_stb with data %h", rx_data);
                end else if (rx_data !== exp_rx[0]) begin
                    n_fail++;
                    $display("FAIL rx_data: got %h, expected %h", rx_data, exp_rx[0]);
                    void'(exp_rx.pop_front());
                end else begin
                    void'(exp_rx.pop_front());
                end
            end
`endif
            if (stb && ready) begin
                hs_cnt++;
                hs_cyc = cyc;
                for (int k = 0; k < 8; k++) begin
                    exp_rise.push_back('{b: data[7-k], cyc: cyc + 1 + (2 * k + 1) * DIV});
                end
                exp_done.push_back(cyc + 1 + 16 * DIV);
                exp_rx.push_back(data);
            end
        end
        prev_sck = spi_sck;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_rise.delete();
        exp_done.delete();
        exp_rx.delete();
    endtask

    // Presents a byte and holds stb until the handshake cycle has been sampled.
    task automatic start_byte(input logic [7:0] d);
        int h0;
        h0   = hs_cnt;
        data = d;
        stb  = 1'b1;
        for (int i = 0; i < 200 && hs_cnt == h0; i++) step();
        n_run++;
        if (hs_cnt == h0) begin
            n_fail++;
            $display("FAIL handshake: byte %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic check_drained(input string name);
        n_run++;
        if (exp_rise.size() != 0 || exp_done.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d rises and %0d dones outstanding, expected 0",
                     name, exp_rise.size(), exp_done.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_run++;
        if ({smp_sck, smp_csn, smp_sdo, smp_done, smp_ready} !== 5'b01001) begin
            n_fail++;
            $display("FAIL reset_outputs: sck,csn,sdo,done,ready=%b, expected 01001",
                     {smp_sck, smp_csn, smp_sdo, smp_done, smp_ready});
        end
`ifdef SPI_CTL_TX_RX_EN
        n_run++;
        if (rx_data !== 8'h00 || rx_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rx: rx_data=%h rx_stb=%b, expected 00 0", rx_data, rx_stb);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int c0, rel, r0, d0;
        r0 = rise_cnt;
        d0 = done_cnt;
        start_byte(8'hA5);
        stb = 1'b0;
        c0  = hs_cyc;
        for (int i = 0; i < 80; i++) begin
            step();
            rel = smp_cyc - c0;
            n_run++;
            if (smp_csn !== ((rel >= 1 && rel <= 17 * DIV) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL single_csn: csn=%b at rel cycle %0d", smp_csn, rel);
            end
            if (rel == 16 * DIV || rel == 18 * DIV || rel == 18 * DIV + 1) begin
                n_run++;
                if (smp_ready !== (rel != 18 * DIV)) begin
                    n_fail++;
                    $display("FAIL single_ready: ready=%b at rel cycle %0d", smp_ready, rel);
                end
            end
        end
        n_run++;
        if (rise_cnt - r0 != 8 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL single_counts: rises=%0d dones=%0d, expected 8 and 1", rise_cnt - r0, done_cnt - d0);
        end
        check_drained("single");
    endtask

    task automatic test_burst();
        int c0, rel, r0, d0, h0;
        logic second;
        r0 = rise_cnt;
        d0 = done_cnt;
        second = 1'b0;
        start_byte(8'h3C);
        c0   = hs_cyc;
        h0   = hs_cnt;
        data = 8'hFF;
        for (int i = 0; i < 150; i++) begin
            step();
            rel = smp_cyc - c0;
            if (!second && hs_cnt != h0) begin
                second = 1'b1;
                stb    = 1'b0;
                n_run++;
                if (hs_cyc - c0 != 16 * DIV) begin
                    n_fail++;
                    $display("FAIL burst_accept: second byte at rel cycle %0d, expected %0d", hs_cyc - c0, 16 * DIV);
                end
            end
            n_run++;
            if (smp_csn !== ((rel >= 1 && rel <= 33 * DIV) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL burst_csn: csn=%b at rel cycle %0d", smp_csn, rel);
            end
        end
        stb = 1'b0;
        n_run++;
        if (rise_cnt - r0 != 16 || done_cnt - d0 != 2 || !second) begin
            n_fail++;
            $display("FAIL burst_counts: rises=%0d dones=%0d second=%b, expected 16 2 1",
                     rise_cnt - r0, done_cnt - d0, second);
        end
        check_drained("burst");
    endtask

    task automatic test_ignore();
        int c0, rel, r0, d0, h0;
        r0 = rise_cnt;
        d0 = done_cnt;
        start_byte(8'h66);
        stb = 1'b0;
        c0  = hs_cyc;
        h0  = hs_cnt;
        for (int i = 0; i < 80; i++) begin
            step();
            rel  = smp_cyc - c0;
            stb  = (rel == 19);
            data = (rel == 19) ? 8'hFF : 8'h66;
        end
        n_run++;
        if (rise_cnt - r0 != 8 || done_cnt - d0 != 1 || hs_cnt != h0) begin
            n_fail++;
            $display("FAIL ignore_busy: rises=%0d dones=%0d extra_hs=%0d, expected 8 1 0",
                     rise_cnt - r0, done_cnt - d0, hs_cnt - h0);
        end
        check_drained("ignore");
    endtask

    task automatic test_abort();
        int c0, r0, d0;
        start_byte(8'hC3);
        stb = 1'b0;
        c0  = hs_cyc;
        for (int i = 0; i < 40 && smp_cyc - c0 < 29; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        flush();
        step();
        n_run++;
        if (smp_cyc - c0 != 31 || smp_csn !== 1'b1 || smp_sck !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: rel cycle %0d csn=%b sck=%b, expected 31 1 0", smp_cyc - c0, smp_csn, smp_sck);
        end
        d0 = done_cnt;
        for (int i = 0; i < 60; i++) step();
        n_run++;
        if (done_cnt != d0 || rise_cnt != rise_cnt) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d dones after reset, expected 0", done_cnt - d0);
        end
        r0 = rise_cnt;
        start_byte(8'h81);
        stb = 1'b0;
        for (int i = 0; i < 80; i++) step();
        n_run++;
        if (rise_cnt - r0 != 8 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL abort_recover: rises=%0d dones=%0d, expected 8 1", rise_cnt - r0, done_cnt - d0);
        end
        check_drained("abort");
    endtask

    task automatic test_div1();
        int   c1, rel;
        logic got_hs;
        logic exp_sck;
        logic [7:0] d1v;
        d1v    = 8'h01;
        data1  = d1v;
        stb1   = 1'b1;
        got_hs = 1'b0;
        c1     = 0;
        for (int i = 0; i < 10 && !got_hs; i++) begin
            step();
            if (smp1_hs) begin
                got_hs = 1'b1;
                c1     = smp_cyc;
            end
        end
        stb1 = 1'b0;
        n_run++;
        if (!got_hs) begin
            n_fail++;
            $display("FAIL div1_handshake: not accepted, expected accept");
        end
        for (int i = 0; i < 22; i++) begin
            step();
            rel     = smp_cyc - c1;
            exp_sck = (rel >= 2 && rel <= 16 && (rel % 2) == 0);
            n_run++;
            if (smp1_sck !== exp_sck || smp1_done !== (rel == 17)) begin
                n_fail++;
                $display("FAIL div1_timing: rel %0d sck=%b done=%b, expected sck=%b done=%b",
                         rel, smp1_sck, smp1_done, exp_sck, (rel == 17));
            end
            if (exp_sck) begin
                n_run++;
                if (smp1_sdo !== d1v[7 - (rel - 2) / 2]) begin
                    n_fail++;
                    $display("FAIL div1_sdo: rel %0d sdo=%b, expected %b", rel, smp1_sdo, d1v[7 - (rel - 2) / 2]);
                end
            end
        end
    endtask

`ifdef SPI_CTL_TX_RX_EN
    task automatic test_rx_loop();
        int r0, h0;
        r0 = rx_cnt;
        start_byte(8'hA5);
        h0   = hs_cnt;
        data = 8'h5A;
        for (int i = 0; i < 100 && hs_cnt == h0; i++) step();
        stb = 1'b0;
        for (int i = 0; i < 80; i++) step();
        n_run++;
        if (rx_cnt - r0 != 2 || rx_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL rx_loop: rx pulses=%0d last=%h, expected 2 5a", rx_cnt - r0, rx_data);
        end
        check_drained("rx_loop");
    endtask
`endif

    initial begin
        rst   = 1'b1;
        stb   = 1'b0;
        data  = 8'h00;
        stb1  = 1'b0;
        data1 = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_ignore();
        test_abort();
        test_div1();
`ifdef SPI_CTL_TX_RX_EN
        test_rx_loop();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
